bcd_7seg_scan: RTL and testbench

- Multiplexed 7-segment display driver placed directly downstream of the BCD up counter(s).
- Captures a packed bus of BCD digits into a shadow register when load is high.
- Scans the digits one at a time, with a blanking cycle at the start of each slot to prevent ghosting.
- Invalid codes (>9) display as a dash and raise an error flag.

---
 rtl/bcd_7seg_scan.sv | 133 +++++++++++++
 tb/tb_bcd_7seg_scan.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bcd_7seg_scan.sv
// Multiplexed 7-segment scanner: shadow-registered BCD digits, one blanking cycle per slot.
// Optional leading-zero blanking when BCD_LZ_BLANK_EN is defined.
module bcd_7seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4,
  parameter int SEL_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst_syn,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SEL_W-1:0]        digit_sel,
  output logic                    bcd_err
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]    PRESC_MAX = CW'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [CW-1:0]           presc_q, presc_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [0:0]              state_q, state_d;
  logic                    run_q;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    err_q, err_d;
  logic [NUM_DIGITS-1:0]   lz_vec;
  logic                    hz;
  logic [3:0]              cur_digit;
  logic                    cur_lz;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'h3F;
      4'd1:    encode = 7'h06;
      4'd2:    encode = 7'h5B;
      4'd3:    encode = 7'h4F;
      4'd4:    encode = 7'h66;
      4'd5:    encode = 7'h6D;
      4'd6:    encode = 7'h7D;
      4'd7:    encode = 7'h07;
      4'd8:    encode = 7'h7F;
      4'd9:    encode = 7'h6F;
      default: encode = 7'h40;
    endcase
  endfunction

  // run_q holds the slot counters at digit 0 BLANK for the first cycle after reset release.
  always_comb begin
    presc_d = presc_q;
    sel_d   = sel_q;
    if (!run_q) begin
      presc_d = '0;
      sel_d   = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      sel_d   = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
    end else begin
      presc_d = presc_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: state_d = run_q ? ST_SHOW : ST_BLANK;
      ST_SHOW:  state_d = (presc_q == PRESC_MAX) ? ST_BLANK : ST_SHOW;
      default:  state_d = ST_BLANK;
    endcase
  end

  always_comb begin
    hz     = 1'b1;
    lz_vec = '0;
`ifdef BCD_LZ_BLANK_EN
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hz        = hz & (shadow_q[4*i +: 4] == 4'd0);
      lz_vec[i] = hz && (i > 0);
    end
`endif
  end

  // Outputs are computed from next-state counters so they line up with digit_sel.
  always_comb begin
    cur_digit = '0;
    cur_lz    = 1'b0;
    an_d      = '1;
    err_d     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_d == SEL_W'(i)) begin
        cur_digit = shadow_q[4*i +: 4];
        cur_lz    = lz_vec[i];
        an_d[i]   = (state_d != ST_SHOW);
      end
      if (shadow_q[4*i +: 4] > 4'd9) err_d = 1'b1;
    end
    seg_d = (state_d == ST_SHOW && !cur_lz && hz == hz) ? encode(cur_digit) : 7'h00;
  end

  always_ff @(posedge clk) begin
    if (rst_syn) begin
      shadow_q <= '0;
      presc_q  <= '0;
      sel_q    <= '0;
      state_q  <= ST_BLANK;
      run_q    <= 1'b0;
      an_q     <= '1;
      seg_q    <= 7'h00;
      err_q    <= 1'b0;
    end else begin
      if (load) shadow_q <= bcd_in;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      state_q <= state_d;
      run_q   <= 1'b1;
      an_q    <= an_d;
      seg_q   <= seg_d;
      err_q   <= err_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign digit_sel = sel_q;
  assign bcd_err   = err_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed plus random bench for bcd_7seg_scan against a frame-position reference model.
module tb_bcd_7seg_scan;

  localparam int ND = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_syn;
  logic [15:0] bcd_in;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        bcd_err;

  int checks = 0;
  int errors = 0;

  bcd_7seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .SEL_W(2)) dut (
    .clk(clk), .rst_syn(rst_syn), .bcd_in(bcd_in), .load(load),
    .seg(seg), .an(an), .digit_sel(digit_sel), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  logic [6:0] enc_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Model: shadow contents and the cycle index k since the post-reset hold cycle.
  logic [15:0] m_sh = '0;
  bit          m_in_rst = 1'b1;
  int          m_k = 0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic [1:0]  e_sel;
  logic        e_err;

  function automatic logic any_bad(input logic [15:0] v);
    logic r = 1'b0;
    for (int i = 0; i < ND; i++) if (((v >> (4*i)) & 16'hF) > 16'd9) r = 1'b1;
    return r;
  endfunction

  function automatic logic [6:0] show_seg(input logic [15:0] v, input int s);
    logic [3:0] d;
    d = 4'((v >> (4*s)) & 16'hF);
`ifdef BCD_LZ_BLANK_EN
    if (s > 0 && (v >> (4*s)) == 16'h0) return 7'h00;
`endif
    return enc_tab[d];
  endfunction

  task automatic step(input logic r, input logic ld, input logic [15:0] din);
    logic [15:0] sh_old;
    int pos, p;
    rst_syn = r;
    load    = ld;
    bcd_in  = din;
    @(posedge clk);
    sh_old = m_sh;
    if (r) begin
      m_sh = '0;
      m_in_rst = 1'b1;
      e_an = 4'hF; e_seg = 7'h00; e_sel = 2'd0; e_err = 1'b0;
    end else begin
      if (ld) m_sh = din;
      if (m_in_rst) begin m_k = 0; m_in_rst = 1'b0; end
      else m_k++;
      pos   = m_k % (ND*SD);
      p     = pos % SD;
      e_sel = 2'(pos / SD);
      e_err = any_bad(sh_old);
      if (p == 0) begin
        e_an = 4'hF; e_seg = 7'h00;
      end else begin
        e_an  = ~(4'b0001 << e_sel);
        e_seg = show_seg(sh_old, int'(e_sel));
      end
    end
    #1;
    checks++;
    assert (an === e_an) else begin
      errors++; $error("FAIL an: got %b exp %b (k=%0d)", an, e_an, m_k);
    end
    checks++;
    assert (seg === e_seg) else begin
      errors++; $error("FAIL seg: got %h exp %h (k=%0d)", seg, e_seg, m_k);
    end
    checks++;
    assert (digit_sel === e_sel) else begin
      errors++; $error("FAIL digit_sel: got %0d exp %0d (k=%0d)", digit_sel, e_sel, m_k);
    end
    checks++;
    assert (bcd_err === e_err) else begin
      errors++; $error("FAIL bcd_err: got %b exp %b (k=%0d)", bcd_err, e_err, m_k);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'(($urandom)));
  endtask

  initial begin
    rst_syn = 1'b1; load = 1'b0; bcd_in = '0;
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h8888);

    step(1'b0, 1'b1, 16'h1234);
    idle(20);

    step(1'b0, 1'b1, 16'h00A5);
    idle(18);
    step(1'b0, 1'b1, 16'h0005);
    idle(5);

    step(1'b0, 1'b1, 16'h9999);
    idle(20);

    while ((m_k % (ND*SD)) != 8) idle(1);
    step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    idle(20);

    step(1'b0, 1'b1, 16'h0007);
    idle(17);
    step(1'b0, 1'b1, 16'h0A07);
    idle(17);

    step(1'b1, 1'b1, 16'h5555);
    idle(20);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 1) == 0) ? 16'($urandom) : {4'($urandom_range(0, 9)),
          4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0), d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
